ctrl_seq: RTL and testbench
===========================

Name: ctrl_seq

Overview:
- T-state sequencer and instruction decoder for the 8-bit-bus accumulator CPU.
- Drives every load, output-enable and strobe line of the datapath: PC, MAR, RAM, IR, A, B, ALU and OUT.
- Runs a 3-state fetch (T1-T3), then a variable-length execute (T4-T6) chosen by the IR opcode.
- Sits beside the datapath; consumes the IR opcode and the ALU zero flag.

Parameters:
- OPW, 4: opcode width (IR bits [7:4]).
- HLT_OP, 4'hF: opcode that halts the sequencer.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- run  in  1  enable; sampled only in T1.
- opcode  in  OPW  IR high nibble; valid from T4.
- zero  in  1  ALU zero flag; sampled in T4.
- pc_inc  out  1  PC increment.
- load_pc  out  1  PC parallel load from bus.
- pc_oen  out  1  PC drives bus.
- load_mar  out  1  MAR load from bus.
- ram_oen  out  1  RAM drives bus.
- ram_we  out  1  RAM write from bus.
- load_ir  out  1  IR load.
- ir_oen  out  1  IR low nibble, zero-extended, drives bus.
- load_a  out  1  A load.
- a_oen  out  1  A drives bus.
- load_b  out  1  B load.
- alu_oen  out  1  ALU drives bus.
- alu_sub  out  1  ALU subtract select.
- load_out  out  1  output register load.
- halted  out  1  high in HALT.
- tstate  out  3  current state: T1=1 … T6=6, HALT=7.

Behaviour:
- Timing rules:
  - State register is clocked on clk.
  - Strobes are combinational from the registered state and `opcode`/`zero`.
  - The datapath captures strobed values at the rising edge that ends the state.
- Reset:
  - clr=1 forces state T1 immediately.
  - All strobes are 0 while clr is high; halted=0, tstate=1.
  - clr asserted mid-instruction aborts the instruction; no further strobes.
- T1:
  - run=1: pc_oen and load_mar asserted; next state T2.
  - run=0: all strobes 0; stay in T1.
- T2: pc_inc asserted; next state T3.
- T3: ram_oen and load_ir asserted; next state T4. `run` is ignored from T2 until the next T1.
- Execute by opcode:
  - Strobes are listed per state.
  - After the last listed state, the next state is T1.
- 0x0 NOP and all undefined opcodes: T4 no strobes.
- 0x1 LDA:
  - T4: ir_oen, load_mar.
  - T5: ram_oen, load_a.
- 0x2 ADD:
  - T4: ir_oen, load_mar.
  - T5: ram_oen, load_b.
  - T6: alu_oen, load_a.
- 0x3 SUB: as ADD, with alu_sub=1 during T6 only.
- 0x4 STA:
  - T4: ir_oen, load_mar.
  - T5: a_oen, ram_we.
- 0x5 JMP: T4: ir_oen, load_pc.
- 0x6 JZ:
  - zero=1 in T4: ir_oen, load_pc.
  - zero=0 in T4: no strobes.
  - Either way, next state T1.
- 0xE OUT: T4: a_oen, load_out.
- HLT_OP: T4 no strobes; next state HALT.
- HALT:
  - All strobes 0; halted=1.
  - Left only by clr; `run` is ignored.
- Invariants:
  - At most one of pc_oen, ram_oen, ir_oen, a_oen, alu_oen is high in any cycle.
  - load_pc and pc_inc are never high together.
- Instruction length in cycles: NOP/JMP/JZ/OUT/HLT 4, LDA/STA 5, ADD/SUB 6.

Optional Feature:
- Macro: CTRL_SEQ_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - In T1 with run=0, a rising edge on `step` lets exactly one instruction execute.
  - Edge detection uses an internal flop; the flop is cleared by clr.
  - Holding step high does not repeat.
  - The instruction proceeds from T1 on the cycle after the detected edge.
  - It then returns to T1 and waits.
  - run=1 overrides `step`.
- Undefined: no `step` port; T1 advances only on run=1.

Test Plan:
- Reset and hold:
  - Stimulus: clr=1 for 3 cycles with run=1, then release with run=0 for 5 cycles.
  - Required: tstate=1 throughout; all strobes 0; halted=0.
- LDA fetch/execute:
  - Stimulus: run=1, opcode=0x1.
  - Required, one state per cycle:
    - T1: pc_oen, load_mar.
    - T2: pc_inc.
    - T3: ram_oen, load_ir.
    - T4: ir_oen, load_mar.
    - T5: ram_oen, load_a.
    - Then tstate=1 on cycle 6.
- SUB:
  - Stimulus: opcode=0x3.
  - Required: T6 shows alu_oen, load_a, alu_sub=1; alu_sub=0 in every other cycle; instruction takes 6 cycles.
- JZ:
  - Stimulus: opcode=0x6, zero=1 in T4; repeat with zero=0.
  - Required: zero=1 gives load_pc and ir_oen in T4; zero=0 gives no strobes in T4. Both return to T1 after 4 cycles.
- HLT then recovery:
  - Stimulus: opcode=0xF; hold run=1 for 10 cycles; then pulse clr mid-HALT.
  - Required:
    - tstate=7 and halted=1 from cycle 5 onward, all strobes 0.
    - clr returns tstate=1 asynchronously, before the next clock edge.
- Bus exclusivity:
  - Stimulus: random opcodes 0x0-0xF with random zero, 500 instructions.
  - Required: never more than one *_oen high in any cycle; load_pc and pc_inc never high together.

Source files
------------

// File: rtl/ctrl_seq.sv
// ctrl_seq: T-state sequencer and instruction decoder for the 8-bit-bus
// accumulator CPU. Fetch runs T1-T3; execute runs T4-T6 depending on the
// IR opcode. HLT parks the sequencer in HALT until clr.
// Optional single-step input is enabled by defining CTRL_SEQ_STEP_EN.
module ctrl_seq #(
  parameter int unsigned          OPW    = 4,
  parameter logic [OPW-1:0]       HLT_OP = OPW'('hF)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           run,
`ifdef CTRL_SEQ_STEP_EN
  input  logic           step,
`endif
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           pc_inc,
  output logic           load_pc,
  output logic           pc_oen,
  output logic           load_mar,
  output logic           ram_oen,
  output logic           ram_we,
  output logic           load_ir,
  output logic           ir_oen,
  output logic           load_a,
  output logic           a_oen,
  output logic           load_b,
  output logic           alu_oen,
  output logic           alu_sub,
  output logic           load_out,
  output logic           halted,
  output logic [2:0]     tstate
);

  typedef enum logic [2:0] {
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    HALT = 3'd7
  } state_t;

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_JMP = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'hE);

  state_t state_q, state_d;
  logic   go;        // T1 may start a fetch this cycle
  logic   is_hlt;
  logic   needs_t5;  // instruction has a memory operand phase
  logic   needs_t6;  // instruction has an ALU writeback phase

  assign is_hlt   = (opcode == HLT_OP);
  assign needs_t5 = !is_hlt && ((opcode == OP_LDA) || (opcode == OP_ADD) ||
                                (opcode == OP_SUB) || (opcode == OP_STA));
  assign needs_t6 = !is_hlt && ((opcode == OP_ADD) || (opcode == OP_SUB));

`ifdef CTRL_SEQ_STEP_EN
  logic step_q;
  logic arm_q;
  logic step_rise;

  assign step_rise = step && !step_q;
  assign go        = run || arm_q;

  // Step edge detector; arm_q releases exactly one instruction from T1.
  // A rise is armed on one cycle and the fetch starts on the next.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      step_q <= step;
      if (state_q == T1 && arm_q)
        arm_q <= 1'b0;
      else if (state_q == T1 && !run && step_rise)
        arm_q <= 1'b1;
    end
  end
`else
  assign go = run;
`endif

  // State register; clr forces T1 immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= T1;
    else     state_q <= state_d;
  end

  // Next-state: fixed fetch, then execute length chosen by opcode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      T1:      state_d = go ? T2 : T1;
      T2:      state_d = T3;
      T3:      state_d = T4;
      T4: begin
        if (is_hlt)        state_d = HALT;
        else if (needs_t5) state_d = T5;
        else               state_d = T1;
      end
      T5:      state_d = needs_t6 ? T6 : T1;
      T6:      state_d = T1;
      HALT:    state_d = HALT;
      default: state_d = T1;
    endcase
  end

  // Strobe decode from registered state plus opcode/zero; forced low in clr.
  always_comb begin
    pc_inc   = 1'b0;
    load_pc  = 1'b0;
    pc_oen   = 1'b0;
    load_mar = 1'b0;
    ram_oen  = 1'b0;
    ram_we   = 1'b0;
    load_ir  = 1'b0;
    ir_oen   = 1'b0;
    load_a   = 1'b0;
    a_oen    = 1'b0;
    load_b   = 1'b0;
    alu_oen  = 1'b0;
    alu_sub  = 1'b0;
    load_out = 1'b0;
    if (!clr) begin
      unique case (state_q)
        T1: begin
          pc_oen   = go;
          load_mar = go;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_oen = 1'b1;
          load_ir = 1'b1;
        end
        T4: begin
          if (needs_t5) begin
            ir_oen   = 1'b1;
            load_mar = 1'b1;
          end else if (!is_hlt && opcode == OP_JMP) begin
            ir_oen  = 1'b1;
            load_pc = 1'b1;
          end else if (!is_hlt && opcode == OP_JZ) begin
            ir_oen  = zero;
            load_pc = zero;
          end else if (!is_hlt && opcode == OP_OUT) begin
            a_oen    = 1'b1;
            load_out = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_STA) begin
            a_oen  = 1'b1;
            ram_we = 1'b1;
          end else begin
            ram_oen = 1'b1;
            load_a  = (opcode == OP_LDA);
            load_b  = needs_t6;
          end
        end
        T6: begin
          alu_oen = 1'b1;
          load_a  = 1'b1;
          alu_sub = (opcode == OP_SUB);
        end
        default: ;
      endcase
    end
  end

  // Status outputs straight from the state register.
  always_comb begin
    tstate = state_q;
    halted = (state_q == HALT);
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: instruction-level reference model plus
// directed instruction sequences with literal expectations.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       run = 1'b0;
  logic       zero = 1'b0;
  logic [3:0] opcode = 4'h0;
`ifdef CTRL_SEQ_STEP_EN
  logic       step = 1'b0;
`endif

  logic pc_inc, load_pc, pc_oen, load_mar, ram_oen, ram_we, load_ir, ir_oen;
  logic load_a, a_oen, load_b, alu_oen, alu_sub, load_out, halted;
  logic [2:0] tstate;

  ctrl_seq #(.OPW(4), .HLT_OP(4'hF)) dut (
    .clk(clk), .clr(clr), .run(run),
`ifdef CTRL_SEQ_STEP_EN
    .step(step),
`endif
    .opcode(opcode), .zero(zero),
    .pc_inc(pc_inc), .load_pc(load_pc), .pc_oen(pc_oen), .load_mar(load_mar),
    .ram_oen(ram_oen), .ram_we(ram_we), .load_ir(load_ir), .ir_oen(ir_oen),
    .load_a(load_a), .a_oen(a_oen), .load_b(load_b), .alu_oen(alu_oen),
    .alu_sub(alu_sub), .load_out(load_out), .halted(halted), .tstate(tstate)
  );

  always #5 clk = ~clk;

  // Strobe bit positions in the packed vector
  localparam logic [13:0] M_PCINC  = 14'h2000;
  localparam logic [13:0] M_LPC    = 14'h1000;
  localparam logic [13:0] M_PCOEN  = 14'h0800;
  localparam logic [13:0] M_LMAR   = 14'h0400;
  localparam logic [13:0] M_RAMOEN = 14'h0200;
  localparam logic [13:0] M_RAMWE  = 14'h0100;
  localparam logic [13:0] M_LIR    = 14'h0080;
  localparam logic [13:0] M_IROEN  = 14'h0040;
  localparam logic [13:0] M_LA     = 14'h0020;
  localparam logic [13:0] M_AOEN   = 14'h0010;
  localparam logic [13:0] M_LB     = 14'h0008;
  localparam logic [13:0] M_ALUOEN = 14'h0004;
  localparam logic [13:0] M_SUB    = 14'h0002;
  localparam logic [13:0] M_LOUT   = 14'h0001;

  logic [13:0] strb;
  assign strb = {pc_inc, load_pc, pc_oen, load_mar, ram_oen, ram_we, load_ir,
                 ir_oen, load_a, a_oen, load_b, alu_oen, alu_sub, load_out};

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Cycles spent in execute after the 3-cycle fetch.
  function automatic int exec_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 2;
      4'h2, 4'h3: return 3;
      default:    return 1;
    endcase
  endfunction

  // Strobes required in cycle ph (0-based) of an instruction.
  function automatic logic [13:0] exp_strb(input int ph, input logic [3:0] op,
                                           input logic z, input logic r);
    case (ph)
      0: return r ? (M_PCOEN | M_LMAR) : 14'h0;
      1: return M_PCINC;
      2: return M_RAMOEN | M_LIR;
      3: case (op)
           4'h1, 4'h2, 4'h3, 4'h4: return M_IROEN | M_LMAR;
           4'h5: return M_IROEN | M_LPC;
           4'h6: return z ? (M_IROEN | M_LPC) : 14'h0;
           4'hE: return M_AOEN | M_LOUT;
           default: return 14'h0;
         endcase
      4: case (op)
           4'h1: return M_RAMOEN | M_LA;
           4'h2, 4'h3: return M_RAMOEN | M_LB;
           4'h4: return M_AOEN | M_RAMWE;
           default: return 14'h0;
         endcase
      5: return M_ALUOEN | M_LA | ((op == 4'h3) ? M_SUB : 14'h0);
      default: return 14'h0;
    endcase
  endfunction

  int mph = 0;   // cycle index within the current instruction
  bit mhalt = 0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mph = 0;
      mhalt = 0;
    end else if (!mhalt) begin
      if (mph == 0) begin
        if (run) mph = 1;
      end else if (mph == 2 + exec_len(opcode)) begin
        if (opcode == 4'hF) mhalt = 1;
        mph = 0;
      end else begin
        mph = mph + 1;
      end
    end
  end

  // Per-cycle compare against the model, plus bus invariants.
  always @(negedge clk) begin
    logic [13:0] es;
    int et;
    bit eh;
    int noen;
    if (chk_en) begin
      if (clr) begin
        es = 14'h0; et = 1; eh = 0;
      end else if (mhalt) begin
        es = 14'h0; et = 7; eh = 1;
      end else begin
        es = exp_strb(mph, opcode, zero, run); et = mph + 1; eh = 0;
      end
      chk("tstate", 32'(tstate), 32'(et));
      chk("halted", 32'(halted), 32'(eh));
      chk("strobes", 32'(strb), 32'(es));
      noen = int'(pc_oen) + int'(ram_oen) + int'(ir_oen) + int'(a_oen) + int'(alu_oen);
      chk("oen_excl", 32'(noen <= 1), 32'd1);
      chk("pc_ld_inc", 32'(load_pc & pc_inc), 32'd0);
    end
  end

  // Run one instruction from T1; called at posedge+1 with DUT in T1.
  task automatic do_instr(input logic [3:0] op, input logic z, output int cyc,
                          output logic [13:0] s4, output logic [13:0] s6);
    opcode = op;
    zero   = z;
    run    = 1'b1;
    cyc    = 0;
    s4     = '0;
    s6     = '0;
    do begin
      if (tstate == 3'd4) s4 = strb;
      if (tstate == 3'd6) s6 = strb;
      @(posedge clk);
      #1;
      cyc++;
    end while (!(tstate == 3'd1 || halted) && cyc < 12);
    if (cyc >= 12) chk("instr_timeout", 32'(cyc), 32'd0);
  endtask

  logic [13:0] lda_exp [5];
  int cyc;
  logic [13:0] s4, s6;
  logic [3:0] rop;
  logic rz;

  initial begin
    lda_exp[0] = M_PCOEN | M_LMAR;
    lda_exp[1] = M_PCINC;
    lda_exp[2] = M_RAMOEN | M_LIR;
    lda_exp[3] = M_IROEN | M_LMAR;
    lda_exp[4] = M_RAMOEN | M_LA;
    chk_en = 1'b1;

    // Reset and hold
    run = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tstate", 32'(tstate), 32'd1);
      chk("rst_strobes", 32'(strb), 32'd0);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    run = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_tstate", 32'(tstate), 32'd1);
      chk("hold_strobes", 32'(strb), 32'd0);
      chk("hold_halted", 32'(halted), 32'd0);
    end

    // LDA, cycle by cycle against literals
    @(posedge clk); #1;
    opcode = 4'h1;
    zero   = 1'b0;
    run    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lda_tstate", 32'(tstate), 32'(i + 1));
      chk("lda_strobes", 32'(strb), 32'(lda_exp[i]));
      @(posedge clk); #1;
    end
    run = 1'b0;
    @(negedge clk);
    chk("lda_end", 32'(tstate), 32'd1);
    @(posedge clk); #1;

    // SUB
    do_instr(4'h3, 1'b0, cyc, s4, s6);
    chk("sub_len", 32'(cyc), 32'd6);
    chk("sub_t6", 32'(s6), 32'(M_ALUOEN | M_LA | M_SUB));

    // JZ taken / not taken
    do_instr(4'h6, 1'b1, cyc, s4, s6);
    chk("jz1_len", 32'(cyc), 32'd4);
    chk("jz1_t4", 32'(s4), 32'(M_IROEN | M_LPC));
    do_instr(4'h6, 1'b0, cyc, s4, s6);
    chk("jz0_len", 32'(cyc), 32'd4);
    chk("jz0_t4", 32'(s4), 32'd0);

    // Remaining defined opcodes
    do_instr(4'h2, 1'b0, cyc, s4, s6);
    chk("add_len", 32'(cyc), 32'd6);
    chk("add_t6", 32'(s6), 32'(M_ALUOEN | M_LA));
    do_instr(4'h4, 1'b1, cyc, s4, s6);
    chk("sta_len", 32'(cyc), 32'd5);
    do_instr(4'h5, 1'b0, cyc, s4, s6);
    chk("jmp_len", 32'(cyc), 32'd4);
    chk("jmp_t4", 32'(s4), 32'(M_IROEN | M_LPC));
    do_instr(4'hE, 1'b0, cyc, s4, s6);
    chk("out_t4", 32'(s4), 32'(M_AOEN | M_LOUT));
    do_instr(4'h0, 1'b1, cyc, s4, s6);
    chk("nop_len", 32'(cyc), 32'd4);

    // HLT then asynchronous recovery
    opcode = 4'hF;
    run    = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("hlt_tstate", 32'(tstate), 32'd7);
    chk("hlt_halted", 32'(halted), 32'd1);
    run = 1'b0;
    #1 clr = 1'b1;
    #1;
    chk("clr_async_tstate", 32'(tstate), 32'd1);
    chk("clr_async_halted", 32'(halted), 32'd0);
    chk("clr_async_strobes", 32'(strb), 32'd0);
    #1 clr = 1'b0;
    @(posedge clk); #1;

    // Random opcodes; halts are cleared with a clr pulse
    for (int n = 0; n < 500; n++) begin
      rop = 4'($urandom_range(0, 15));
      rz  = 1'($urandom_range(0, 1));
      do_instr(rop, rz, cyc, s4, s6);
      chk("rnd_len", 32'(cyc), 32'(3 + exec_len(rop)));
      if (rop == 4'hF) begin
        run = 1'b0;
        #1 clr = 1'b1;
        #1 clr = 1'b0;
        @(posedge clk); #1;
      end
    end

    run = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
